// File: rtl/axil_ram_slave.sv
// AXI4-Lite slave backed by an inferred word RAM with byte strobes.
// Write (AW/W/B) and read (AR/R) channels run independently and may fire in the same cycle.
module axil_ram_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready
);

    localparam int WORD_SHIFT       = $clog2(STRB_WIDTH);
    localparam int VALID_ADDR_WIDTH = ADDR_WIDTH - WORD_SHIFT;

    logic [DATA_WIDTH-1:0] mem [2**VALID_ADDR_WIDTH] = '{default: '0};

    logic [VALID_ADDR_WIDTH-1:0] wr_idx;
    logic [VALID_ADDR_WIDTH-1:0] rd_idx;
    logic                        wr_fire;
    logic                        rd_fire;

    logic awready_q, awready_d;
    logic wready_q,  wready_d;
    logic bvalid_q,  bvalid_d;
    logic arready_q, arready_d;
    logic rvalid_q,  rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Protection bits and sub-word address bits carry no meaning for this RAM.
    logic unused_inputs;
    assign unused_inputs = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};

    assign wr_idx = s_axil_awaddr[ADDR_WIDTH-1:WORD_SHIFT];
    assign rd_idx = s_axil_araddr[ADDR_WIDTH-1:WORD_SHIFT];

    assign wr_fire = s_axil_awvalid && s_axil_wvalid && !awready_q && !wready_q
                     && (!bvalid_q || s_axil_bready);
    assign rd_fire = s_axil_arvalid && !arready_q && (!rvalid_q || s_axil_rready);

    always_comb begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = bvalid_q && !s_axil_bready;
        if (wr_fire) begin
            awready_d = 1'b1;
            wready_d  = 1'b1;
            bvalid_d  = 1'b1;
        end
    end

    always_comb begin
        arready_d = 1'b0;
        rvalid_d  = rvalid_q && !s_axil_rready;
        if (rd_fire) begin
            arready_d = 1'b1;
            rvalid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
        end
        // Memory keeps accepting completed writes independent of reset.
        if (wr_fire) begin
            for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
                if (s_axil_wstrb[i]) begin
                    mem[wr_idx][8*i +: 8] <= s_axil_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            if (rd_fire) begin
                rdata_q <= mem[rd_idx];
            end
        end
    end

    assign s_axil_awready = awready_q;
    assign s_axil_wready  = wready_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = 2'b00;
    assign s_axil_arready = arready_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = 2'b00;

endmodule

// File: tb/tb_axil_ram_slave.sv
// Directed self-checking bench for axil_ram_slave with immediate assertions.
module tb_axil_ram_slave;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axil_ram_slave #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .STRB_WIDTH(SW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axil_awaddr (awaddr),
        .s_axil_awprot (awprot),
        .s_axil_awvalid(awvalid),
        .s_axil_awready(awready),
        .s_axil_wdata  (wdata),
        .s_axil_wstrb  (wstrb),
        .s_axil_wvalid (wvalid),
        .s_axil_wready (wready),
        .s_axil_bresp  (bresp),
        .s_axil_bvalid (bvalid),
        .s_axil_bready (bready),
        .s_axil_araddr (araddr),
        .s_axil_arprot (arprot),
        .s_axil_arvalid(arvalid),
        .s_axil_arready(arready),
        .s_axil_rdata  (rdata),
        .s_axil_rresp  (rresp),
        .s_axil_rvalid (rvalid),
        .s_axil_rready (rready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        step();
        rst = 1'b0;
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_wready",  {31'd0, wready},  32'd0);
        check("rst_bvalid",  {31'd0, bvalid},  32'd0);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_rvalid",  {31'd0, rvalid},  32'd0);
        check("rst_rdata",   rdata,            32'd0);

        // Basic write to word 0 via byte address 1
        awaddr = 16'd1; wdata = 32'd2345; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        step();
        check("wr_awready", {31'd0, awready}, 32'd1);
        check("wr_wready",  {31'd0, wready},  32'd1);
        check("wr_bvalid",  {31'd0, bvalid},  32'd1);
        check("wr_bresp",   {30'd0, bresp},   32'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        check("wr_bvalid_clr",  {31'd0, bvalid},  32'd0);
        check("wr_awready_clr", {31'd0, awready}, 32'd0);

        // Read back, byte offsets 1 and 3 select the same word
        araddr = 16'd1; arvalid = 1'b1; rready = 1'b1;
        step();
        check("rd_arready", {31'd0, arready}, 32'd1);
        check("rd_rvalid",  {31'd0, rvalid},  32'd1);
        check("rd_rdata",   rdata,            32'd2345);
        check("rd_rresp",   {30'd0, rresp},   32'd0);
        arvalid = 1'b0;
        step();
        check("rd_rvalid_clr", {31'd0, rvalid}, 32'd0);
        araddr = 16'd3; arvalid = 1'b1;
        step();
        check("rd_off3_rdata", rdata, 32'd2345);
        arvalid = 1'b0;
        step();

        // Strobed write over word 1 (still zero)
        awaddr = 16'd4; wdata = 32'hAABBCCDD; wstrb = 4'b0101;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        araddr = 16'd4; arvalid = 1'b1;
        step();
        check("strb_rdata", rdata, 32'h00BB00DD);
        arvalid = 1'b0;
        step();

        // B-channel backpressure blocks a second write
        bready = 1'b0;
        awaddr = 16'd16; wdata = 32'h11; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        check("bp_bvalid1", {31'd0, bvalid}, 32'd1);
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        awaddr = 16'd12; wdata = 32'h33;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = 16'd12; arvalid = 1'b1;
        step();
        check("bp_bvalid_hold", {31'd0, bvalid},  32'd1);
        check("bp_no_awready",  {31'd0, awready}, 32'd0);
        check("bp_word3_old",   rdata,            32'd0);
        arvalid = 1'b0;
        step();
        check("bp_still_hold", {31'd0, bvalid}, 32'd1);
        bready = 1'b1;
        step();
        check("bp_fire_awready", {31'd0, awready}, 32'd1);
        check("bp_fire_bvalid",  {31'd0, bvalid},  32'd1);
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        check("bp_bvalid_clr", {31'd0, bvalid}, 32'd0);
        araddr = 16'd12; arvalid = 1'b1;
        step();
        check("bp_word3_new", rdata, 32'h33);
        arvalid = 1'b0;
        step();

        // R-channel backpressure: rvalid and rdata hold while rready is low
        rready = 1'b0;
        araddr = 16'd16; arvalid = 1'b1;
        step();
        check("rbp_rdata", rdata, 32'h11);
        arvalid = 1'b0;
        araddr = 16'd0;
        step();
        check("rbp_rvalid_hold", {31'd0, rvalid}, 32'd1);
        check("rbp_rdata_hold",  rdata,           32'h11);
        rready = 1'b1;
        step();
        check("rbp_rvalid_clr", {31'd0, rvalid}, 32'd0);

        // Simultaneous read and write of word 2 returns old data
        awaddr = 16'd8; wdata = 32'd7; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        wdata = 32'd9; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 16'd8; arvalid = 1'b1;
        step();
        check("rw_same_rdata",  rdata,           32'd7);
        check("rw_same_bvalid", {31'd0, bvalid}, 32'd1);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        step();
        arvalid = 1'b1;
        step();
        check("rw_after_rdata", rdata, 32'd9);
        arvalid = 1'b0;
        step();

        // Reset mid-transaction drops the pending response, memory persists
        bready = 1'b0; rready = 1'b0;
        awaddr = 16'd20; wdata = 32'h55; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 16'd8; arvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("mid_rst_rdata",  rdata,           32'd0);
        rready = 1'b1; bready = 1'b1;
        araddr = 16'd20; arvalid = 1'b1;
        step();
        check("mid_rst_mem", rdata, 32'h55);
        arvalid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
